param_seq_memory: RTL and testbench

PARAM_SEQ_MEMORY -- requirements
Module: param_seq_memory

---
 rtl/param_seq_memory_pkg.sv | 14 +
 rtl/param_seq_memory_array.sv | 52 +++++
 rtl/param_seq_memory.sv | 98 +++++++++
 tb/tb_param_seq_memory.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_seq_memory_pkg.sv
// Shared types and constants for the parameterised sequential memory.
// The FSM enum and write-response mode encodings live here.
package param_seq_memory_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int WR_RESP_NONE = 0;
  localparam int WR_RESP_OLD  = 1;
  localparam int WR_RESP_NEW  = 2;

endpackage

// File: rtl/param_seq_memory_array.sv
// Word storage with a byte-enabled synchronous write port and a registered read port.
// The read register resets to zero and holds whenever no read is requested.
module param_seq_memory_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic                rd_zero_i,
  input  logic                rd_merged_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    merged = mem_q[addr_i];
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (be_i[k]) merged[8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  // Storage is deliberately not reset; only the clear sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[addr_i] <= merged;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en_i) begin
      if (rd_zero_i)        rdata_d = '0;
      else if (rd_merged_i) rdata_d = merged;
      else                  rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_seq_memory.sv
// Single-port memory with optional clear-on-reset sweep, byte enables,
// configurable write response and out-of-range error reporting.
module param_seq_memory
  import param_seq_memory_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int WR_RESP        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                err,
  output logic                busy,
  output state_e              dbg_state
);

  // Handshake: a request is taken on a rising edge where req && ready; when
  // ready is low the request is dropped, never queued. rvalid/err are one-cycle
  // pulses registered at the accepting edge.
  state_e            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              accept, in_range, sweep_last;

  assign in_range   = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign busy       = (state_q == INIT);
  assign ready      = run_q && (state_q == IDLE);
  assign accept     = req && ready;
  assign sweep_last = (cnt_q == ADDR_W'(DEPTH - 1));

  // run_q marks the first edge after reset release, where the FSM picks its
  // starting state; until then ready and busy both stay low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = accept && (!we || WR_RESP != WR_RESP_NONE);
    err_d    = accept && !in_range;
    if (!run_q) begin
      state_d = (CLEAR_ON_RESET != 0) ? INIT : IDLE;
    end else if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (sweep_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  param_seq_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (busy || (accept && we && in_range)),
    .rd_en_i     (rvalid_d),
    .rd_zero_i   (!in_range),
    .rd_merged_i (we && (WR_RESP == WR_RESP_NEW)),
    .addr_i      (busy ? cnt_q : addr),
    .wdata_i     (busy ? '0 : wdata),
    .be_i        (busy ? '1 : be),
    .rdata_o     (rdata)
  );

  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_seq_memory.sv
// Bench for param_seq_memory: a default 8-bit instance plus three 32-bit,
// DEPTH=200 instances (one per write-response mode) sharing their inputs.
module tb_param_seq_memory;
  import param_seq_memory_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, we_a;
  logic [7:0]  addr_a, wdata_a;
  logic [0:0]  be_a;
  logic        ready_a, rvalid_a, err_a, busy_a;
  logic [7:0]  rdata_a;
  state_e      dbg_a;

  logic        rst_b, req_b, we_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [3:0]  be_b;
  logic        ready_b [3];
  logic        rvalid_b [3];
  logic        err_b [3];
  logic        busy_b [3];
  logic [31:0] rdata_b [3];
  state_e      dbg_b [3];

  param_seq_memory u_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .be(be_a), .ready(ready_a), .rdata(rdata_a),
    .rvalid(rvalid_a), .err(err_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  for (genvar g = 0; g < 3; g++) begin : g_b
    param_seq_memory #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WR_RESP(g)) u_b (
      .clk(clk), .rst_n(rst_b), .req(req_b), .we(we_b), .addr(addr_b),
      .wdata(wdata_b), .be(be_b), .ready(ready_b[g]), .rdata(rdata_b[g]),
      .rvalid(rvalid_b[g]), .err(err_b[g]), .busy(busy_b[g]), .dbg_state(dbg_b[g])
    );
  end

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_a [256];
  logic [7:0]  last_a;
  logic [31:0] mem_b [256];
  logic [31:0] last_b [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic b);
    logic ev;
    req_a = r; we_a = w; addr_a = a; wdata_a = d; be_a = b;
    ev = r && !w;
    if (r && w && b) mem_a[a] = d;
    if (ev) begin
      exp_q.push_back(32'(mem_a[a]));
      last_a = mem_a[a];
    end
    cyc();
    check("a_rvalid", 32'(rvalid_a), 32'(ev));
    check("a_err", 32'(err_a), 32'd0);
    if (ev) check("a_rdata", 32'(rdata_a), exp_q.pop_front());
    else    check("a_rdata_hold", 32'(rdata_a), 32'(last_a));
  endtask

  task automatic op_b(input logic r, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    logic        inr, ee;
    logic        ev [3];
    logic [31:0] old, nw;
    req_b = r; we_b = w; addr_b = a; wdata_b = d; be_b = b;
    inr = (a < 8'd200);
    old = inr ? mem_b[a] : 32'd0;
    nw  = old;
    for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
    ee = r && !inr;
    for (int m = 0; m < 3; m++) begin
      ev[m] = r && (!w || m != WR_RESP_NONE);
      if (ev[m]) begin
        if (!inr)                   last_b[m] = 32'd0;
        else if (!w)                last_b[m] = old;
        else if (m == WR_RESP_OLD)  last_b[m] = old;
        else                        last_b[m] = nw;
      end
    end
    if (r && w && inr) mem_b[a] = nw;
    cyc();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("b%0d_rvalid", m), 32'(rvalid_b[m]), 32'(ev[m]));
      check($sformatf("b%0d_err", m), 32'(err_b[m]), 32'(ee));
      check($sformatf("b%0d_rdata", m), rdata_b[m], last_b[m]);
    end
  endtask

  // Runs until both sweeps finish (bounded); ignored requests are offered to A throughout.
  task automatic wait_sweep(output int na, output int nb, output int bad);
    na = 0; nb = 0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'($urandom_range(0, 255));
      cyc();
      if (busy_a) na++;
      if (busy_b[0]) nb++;
      if (busy_a && ready_a) bad++;
      if (rvalid_a || err_a) bad++;
      if (!busy_a && !busy_b[0]) break;
    end
    req_a = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int na, nb, bad, n100;
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
    foreach (last_b[i]) last_b[i] = '0;
    last_a = '0;

    repeat (3) cyc();
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    check("rst_rvalid_b", 32'(rvalid_b[0]), 32'd0);

    rst_a = 1'b1; rst_b = 1'b1;
    wait_sweep(na, nb, bad);
    check("sweep_len_a", 32'(na), 32'd256);
    check("sweep_len_b", 32'(nb), 32'd200);
    check("ignored_while_busy", 32'(bad), 32'd0);
    check("a_state_idle", 32'(dbg_a), 32'(IDLE));
    check("a_ready_idle", 32'(ready_a), 32'd1);
    for (int m = 0; m < 3; m++) check($sformatf("b%0d_busy", m), 32'(busy_b[m]), 32'd0);

    // Cleared memory, then read-after-write, byte enable off, back-to-back reads.
    op_a(1, 0, 8'h55, 8'h00, 1'b0);
    op_a(0, 0, 8'h00, 8'h00, 1'b0);
    op_a(1, 1, 8'h01, 8'h11, 1'b1);
    op_a(1, 1, 8'h02, 8'h22, 1'b1);
    op_a(1, 1, 8'h03, 8'h33, 1'b1);
    op_a(1, 0, 8'h03, 8'h00, 1'b0);
    op_a(1, 1, 8'h02, 8'hEE, 1'b0);
    op_a(1, 0, 8'h01, 8'h00, 1'b0);
    op_a(1, 0, 8'h02, 8'h00, 1'b0);
    op_a(1, 0, 8'h03, 8'h00, 1'b0);
    op_a(0, 0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++)
      op_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Mid-sweep reset: outputs drop at once, sweep restarts, old data is gone.
    op_a(1, 1, 8'h07, 8'h5A, 1'b1);
    op_a(1, 0, 8'h07, 8'h00, 1'b0);
    req_a = 1'b0;
    rst_a = 1'b0;
    #1;
    check("arst_rdata", 32'(rdata_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    cyc();
    rst_a = 1'b1;
    n100 = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (busy_a) n100++;
    end
    check("sweep_partial", 32'(n100), 32'd100);
    #2;
    rst_a = 1'b0;
    #1;
    check("mid_ready", 32'(ready_a), 32'd0);
    check("mid_busy", 32'(busy_a), 32'd0);
    check("mid_rvalid", 32'(rvalid_a), 32'd0);
    check("mid_err", 32'(err_a), 32'd0);
    check("mid_rdata", 32'(rdata_a), 32'd0);
    cyc();
    rst_a = 1'b1;
    wait_sweep(na, nb, bad);
    check("resweep_len_a", 32'(na), 32'd256);
    foreach (mem_a[i]) mem_a[i] = '0;
    last_a = '0;
    op_a(1, 0, 8'h07, 8'h00, 1'b0);
    op_a(1, 0, 8'h03, 8'h00, 1'b0);

    // 32-bit group: merge, write responses, out-of-range, then random.
    op_b(1, 1, 8'h55, 32'hDEADBEEF, 4'b1111);
    op_b(1, 1, 8'h55, 32'h00000011, 4'b0001);
    op_b(1, 0, 8'h55, 32'h0, 4'b0000);
    op_b(1, 1, 8'd210, 32'h000000AA, 4'b1111);
    op_b(1, 0, 8'd210, 32'h0, 4'b0000);
    op_b(0, 0, 8'h00, 32'h0, 4'b0000);
    op_b(1, 0, 8'h55, 32'h0, 4'b0000);
    op_b(1, 1, 8'd199, 32'hCAFEF00D, 4'b1010);
    op_b(1, 0, 8'd199, 32'h0, 4'b0000);
    for (int i = 0; i < 300; i++)
      op_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 220)) : 8'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)));
    req_b = 1'b0;

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
